// File: rtl/plain_text_packer.sv
// plain_text_packer
//   Packs a valid/ready byte stream into BYTES-wide plaintext blocks for the
//   AES-128 core. The first byte of a block lands in out_block[7:0], and byte k
//   lands in out_block[8k+7:8k]. A message that ends early (in_last) produces a
//   short block: the unwritten upper bytes are zero and out_len holds the true
//   byte count.
//
//   Storage is one assembly register plus one output register. While the output
//   register is still occupied, a completed block waits in the assembly register
//   (HOLD state) and input is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    plaintext byte
//   in_valid   in_data valid
//   in_last    final byte of message (qualified by in_valid)
//   in_ready   byte accepted this cycle when in_valid & in_ready
//   out_block  packed block, stable while out_valid & !out_ready
//   out_len    valid bytes in out_block (1..BYTES)
//   out_valid  out_block/out_len valid
//   out_ready  consumer takes the block when out_valid & out_ready
module plain_text_packer #(
    parameter int BYTES = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [8*BYTES-1:0] out_block,
    output logic [CNT_W-1:0]   out_len,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [8*BYTES-1:0]   assembly;
    logic [8*BYTES-1:0]   assembly_next;
    logic [8*BYTES-1:0]   assembly_wr;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 out_free;
    logic                 load;
    logic [8*BYTES-1:0]   load_block;
    logic [CNT_W-1:0]     load_len;

    // The output register can take a new block this edge if it is empty or
    // its current block is being consumed on the same edge.
    assign out_free = !out_valid || out_ready;
    assign cnt_inc  = cnt + CNT_W'(1);

    // Assembly contents with the incoming byte placed at slot cnt.
    always_comb begin
        assembly_wr = assembly;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (cnt == CNT_W'(k)) begin
                assembly_wr[8*k +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        load          = 1'b0;
        load_block    = assembly;
        load_len      = cnt;
        assembly_next = assembly;
        cnt_next      = cnt;
        case (state)
            FILL: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    if (cnt_inc == CNT_W'(BYTES) || in_last) begin
                        if (out_free) begin
                            // Completing byte goes straight to the output register.
                            load          = 1'b1;
                            load_block    = assembly_wr;
                            load_len      = cnt_inc;
                            assembly_next = '0;
                            cnt_next      = '0;
                        end else begin
                            assembly_next = assembly_wr;
                            cnt_next      = cnt_inc;
                            state_next    = HOLD;
                        end
                    end else begin
                        assembly_next = assembly_wr;
                        cnt_next      = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    load          = 1'b1;
                    assembly_next = '0;
                    cnt_next      = '0;
                    state_next    = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assembly  <= '0;
            cnt       <= '0;
            out_block <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
        end else begin
            assembly <= assembly_next;
            cnt      <= cnt_next;
            if (load) begin
                out_block <= load_block;
                out_len   <= load_len;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_plain_text_packer.sv
module tb_plain_text_packer;

    localparam int BYTES = 16;
    localparam int CNT_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [8*BYTES-1:0] out_block;
    logic [CNT_W-1:0]   out_len;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plain_text_packer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [15:0][7:0] data;
        int unsigned      n;
        logic             last;
        logic [127:0]     exp_block;
        logic [4:0]       exp_len;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] BLK_00 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_10 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] BLK_20 = 128'h2F2E2D2C2B2A29282726252423222120;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] d, input logic l);
        int unsigned guard;
        guard    = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] first, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(first + 8'(i), 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] q_blk [$];
    logic [4:0]   q_len [$];
    bit           prod_done;
    int unsigned  pulse_idx [$];
    logic [127:0] pulse_blk [$];
    int unsigned  ready_drops;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        prod_done = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[0].data[i] = 8'(i);
            vecs[3].data[i] = 8'(16 + i);
            vecs[1].data[i] = 8'h00;
            vecs[2].data[i] = 8'h00;
        end
        vecs[0].n = 16; vecs[0].last = 1'b0; vecs[0].exp_block = BLK_00;         vecs[0].exp_len = 5'd16;
        vecs[1].data[0] = 8'hAA; vecs[1].data[1] = 8'hBB; vecs[1].data[2] = 8'hCC;
        vecs[1].n = 3;  vecs[1].last = 1'b1; vecs[1].exp_block = 128'hCCBBAA;    vecs[1].exp_len = 5'd3;
        vecs[2].data[0] = 8'h5A;
        vecs[2].n = 1;  vecs[2].last = 1'b1; vecs[2].exp_block = 128'h5A;        vecs[2].exp_len = 5'd1;
        vecs[3].n = 16; vecs[3].last = 1'b1; vecs[3].exp_block = BLK_10;         vecs[3].exp_len = 5'd16;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_block", out_block, 0);
        check("rst_out_len", out_len, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // Table-driven messages, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            for (int unsigned i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].data[i], vecs[v].last && (i == vecs[v].n - 1));
            end
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_block", v), out_block, vecs[v].exp_block);
            check($sformatf("vec%0d_len", v), out_len, vecs[v].exp_len);
            tick();
            check($sformatf("vec%0d_no_extra", v), out_valid, 0);
            check($sformatf("vec%0d_in_ready", v), in_ready, 1);
        end

        // Back-pressure: block 1 held, block 2 waits in HOLD
        out_ready = 1'b0;
        send_run(8'h00, 16);
        check("bp_blk1_valid", out_valid, 1);
        check("bp_blk1_block", out_block, BLK_00);
        send_run(8'h20, 16);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_hold%0d_block", c), out_block, BLK_00);
            check($sformatf("bp_hold%0d_len", c), out_len, 16);
            check($sformatf("bp_hold%0d_in_ready", c), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_blk2_valid", out_valid, 1);
        check("bp_blk2_block", out_block, BLK_20);
        check("bp_blk2_in_ready", in_ready, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Reset mid-block discards partial bytes
        send_run(8'h70, 7);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        send_run(8'h00, 16);
        check("midrst_valid", out_valid, 1);
        check("midrst_block", out_block, BLK_00);
        check("midrst_len", out_len, 16);
        tick();

        // Reset while a block is presented and another is held
        out_ready = 1'b0;
        send_run(8'h00, 16);
        send_run(8'h20, 16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_presented_valid", out_valid, 0);
        check("rst_presented_block", out_block, 0);
        out_ready = 1'b1;
        tick();
        check("rst_presented_no_held", out_valid, 0);

        // Continuous 48-byte stream
        ready_drops = 0;
        in_valid    = 1'b1;
        in_last     = 1'b0;
        for (int unsigned i = 0; i < 48; i++) begin
            in_data = 8'(i);
            @(negedge clk);
            if (!in_ready) ready_drops++;
            tick();
            if (out_valid) begin
                pulse_idx.push_back(i);
                pulse_blk.push_back(out_block);
            end
        end
        in_valid = 1'b0;
        check("stream_in_ready_drops", ready_drops, 0);
        check("stream_block_count", pulse_idx.size(), 3);
        if (pulse_idx.size() == 3) begin
            check("stream_pulse0_at", pulse_idx[0], 15);
            check("stream_gap01", pulse_idx[1] - pulse_idx[0], 16);
            check("stream_gap12", pulse_idx[2] - pulse_idx[1], 16);
            check("stream_blk1", pulse_blk[0], BLK_00);
            check("stream_blk2", pulse_blk[1], BLK_10);
            check("stream_blk3", pulse_blk[2], BLK_20);
        end
        tick();

        // Random traffic against a scoreboard
        fork
            begin : producer
                logic [127:0] cur;
                int unsigned  c;
                int unsigned  idle;
                logic [7:0]   b;
                logic         l;
                cur = '0;
                c   = 0;
                for (int i = 0; i < 1000; i++) begin
                    idle = $urandom_range(0, 3);
                    b    = 8'($urandom);
                    l    = ($urandom_range(0, 9) == 0) || (i == 999);
                    repeat (idle) begin
                        in_valid = 1'b0;
                        in_data  = 8'($urandom);
                        in_last  = 1'($urandom_range(0, 1));
                        tick();
                    end
                    cur[8*c +: 8] = b;
                    c++;
                    if (c == 16 || l) begin
                        q_blk.push_back(cur);
                        q_len.push_back(5'(c));
                        cur = '0;
                        c   = 0;
                    end
                    send_byte(b, l);
                end
                prod_done = 1'b1;
            end
            begin : consumer
                int unsigned  cyc;
                logic         hold;
                logic [127:0] held;
                logic [127:0] eb;
                logic [4:0]   el;
                cyc  = 0;
                hold = 1'b0;
                held = '0;
                while (!(prod_done && q_blk.size() == 0) && cyc < 20000) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                    cyc++;
                    @(negedge clk);
                    if (hold) begin
                        check("rnd_stable_valid", out_valid, 1);
                        check("rnd_stable_block", out_block, held);
                    end
                    if (out_valid && out_ready) begin
                        if (q_blk.size() == 0) begin
                            check("rnd_unexpected_block", out_valid, 0);
                        end else begin
                            eb = q_blk.pop_front();
                            el = q_len.pop_front();
                            check("rnd_block", out_block, eb);
                            check("rnd_len", out_len, el);
                        end
                    end
                    hold = out_valid && !out_ready;
                    held = out_block;
                end
                if (cyc >= 20000) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_timeout: %0d blocks pending, required 0", q_blk.size());
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
